// File: rtl/bsg_counter_overflow_collector_pkg.sv
// Shared types and default widths for the overflow collector.
package bsg_counter_overflow_collector_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        SAT  = 2'd2
    } state_e;

    localparam int WIDTH_P_DEFAULT    = 4;
    localparam int TS_WIDTH_P_DEFAULT = 32;

endpackage

// File: rtl/bsg_counter_overflow_collector_sat_clear.sv
// Saturating up-counter with a clear input that has priority over up.
module bsg_counter_sat_clear #(
    parameter int width_p = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               up,
    input  logic               clear,
    output logic [width_p-1:0] count
);

    localparam logic [width_p-1:0] CntMax = '1;
    localparam logic [width_p-1:0] CntOne = width_p'(1);

    logic [width_p-1:0] count_q;

    // A clear that coincides with an event keeps that event as the new count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= up ? CntOne : '0;
        end else if (up && (count_q != CntMax)) begin
            count_q <= count_q + CntOne;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/bsg_counter_overflow_collector.sv
// Collects overflow pulses into a pending count drained by yumi_i.
// Define BSG_COUNTER_OVERFLOW_COLLECTOR_TIMESTAMP_EN to add timestamp_o.
module bsg_counter_overflow_collector
    import bsg_counter_overflow_collector_pkg::*;
#(
    parameter int width_p    = WIDTH_P_DEFAULT,
    parameter int ts_width_p = TS_WIDTH_P_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  overflow_i,
    input  logic                  yumi_i,
    input  logic                  lost_clr_i,
    output logic                  v_o,
    output logic [width_p-1:0]    data_o,
    output logic                  lost_o,
`ifdef BSG_COUNTER_OVERFLOW_COLLECTOR_TIMESTAMP_EN
    output logic [ts_width_p-1:0] timestamp_o,
`endif
    output logic [1:0]            state_o
);

    localparam logic [width_p-1:0] CntMax = '1;
    localparam logic [width_p-1:0] CntOne = width_p'(1);

    // Handshake: data_o is offered while v_o=1; yumi_i=1 takes every pending
    // event in that cycle. yumi_i while v_o=0 is illegal and has no effect.
    logic               clear;
    logic               up;
    logic [width_p-1:0] count;
    state_e             state_q, state_d;
    logic               v_q;
    logic               lost_q, lost_d;

    assign clear = yumi_i & v_q;
    assign up    = overflow_i;

    bsg_counter_sat_clear #(.width_p(width_p)) pending_cnt (
        .clk   (clk_i),
        .reset (reset_i),
        .up    (up),
        .clear (clear),
        .count (count)
    );

    always_comb begin
        state_d = state_q;
        lost_d  = lost_q;
        if (clear) begin
            state_d = up ? ((CntOne == CntMax) ? SAT : PEND) : IDLE;
        end else if (up) begin
            state_d = ((state_q == SAT) || (count == CntMax - CntOne)) ? SAT : PEND;
        end
        // A lost event in the same cycle as lost_clr_i keeps the flag set.
        if (up && !clear && (state_q == SAT)) begin
            lost_d = 1'b1;
        end else if (lost_clr_i) begin
            lost_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            v_q     <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            v_q     <= (state_d != IDLE);
            lost_q  <= lost_d;
        end
    end

`ifdef BSG_COUNTER_OVERFLOW_COLLECTOR_TIMESTAMP_EN
    logic [ts_width_p-1:0] ts_cnt_q;
    logic [ts_width_p-1:0] ts_q;

    // Capture on the event that takes the count from zero to one.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ts_cnt_q <= '0;
            ts_q     <= '0;
        end else begin
            ts_cnt_q <= ts_cnt_q + ts_width_p'(1);
            if (up && ((state_q == IDLE) || clear)) begin
                ts_q <= ts_cnt_q;
            end
        end
    end

    assign timestamp_o = ts_q;
`endif

    assert property (@(posedge clk_i) disable iff (reset_i) !(yumi_i && !v_q));

    assign v_o     = v_q;
    assign data_o  = count;
    assign lost_o  = lost_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_bsg_counter_overflow_collector.sv
// Directed and scoreboarded bench for bsg_counter_overflow_collector.
module tb_bsg_counter_overflow_collector;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        overflow_i;
    logic        yumi_i;
    logic        lost_clr_i;
    logic        v_o;
    logic [3:0]  data_o;
    logic        lost_o;
    logic [1:0]  state_o;
`ifdef BSG_COUNTER_OVERFLOW_COLLECTOR_TIMESTAMP_EN
    logic [31:0] timestamp_o;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [4:0] exp_q[$];

    bsg_counter_overflow_collector dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .overflow_i (overflow_i),
        .yumi_i     (yumi_i),
        .lost_clr_i (lost_clr_i),
        .v_o        (v_o),
        .data_o     (data_o),
        .lost_o     (lost_o),
`ifdef BSG_COUNTER_OVERFLOW_COLLECTOR_TIMESTAMP_EN
        .timestamp_o(timestamp_o),
`endif
        .state_o    (state_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        overflow_i = 1'b0;
        yumi_i = 1'b0;
        lost_clr_i = 1'b0;
        tick();
        tick();
        reset_i = 1'b0;
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            overflow_i = 1'b1;
            tick();
        end
        overflow_i = 1'b0;
    endtask

    task automatic drain();
        yumi_i = 1'b1;
        tick();
        yumi_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        overflow_i = 1'b0;
        yumi_i = 1'b0;
        lost_clr_i = 1'b0;
        tick();
        n_cmp++;
        if ({v_o, data_o, lost_o, state_o} !== 8'b0) begin
            n_err++;
            $display("FAIL reset: v=%0b data=%0d lost=%0b state=%0d, need all 0", v_o, data_o, lost_o, state_o);
        end
        tick();
        reset_i = 1'b0;
    endtask

    task automatic test_three_pulses();
        do_reset();
        pulses(1);
        n_cmp++;
        if (v_o !== 1'b1 || data_o !== 4'd1 || state_o !== 2'd1) begin
            n_err++;
            $display("FAIL latency: v=%0b data=%0d state=%0d, need 1/1/1", v_o, data_o, state_o);
        end
        pulses(2);
        n_cmp++;
        if (v_o !== 1'b1 || data_o !== 4'd3 || lost_o !== 1'b0) begin
            n_err++;
            $display("FAIL three_pulses: v=%0b data=%0d lost=%0b, need 1/3/0", v_o, data_o, lost_o);
        end
        drain();
        n_cmp++;
        if (v_o !== 1'b0 || data_o !== 4'd0 || state_o !== 2'd0) begin
            n_err++;
            $display("FAIL drain: v=%0b data=%0d state=%0d, need 0/0/0", v_o, data_o, state_o);
        end
    endtask

    task automatic test_yumi_with_overflow();
        do_reset();
        pulses(5);
        n_cmp++;
        if (data_o !== 4'd5) begin
            n_err++;
            $display("FAIL five_pulses: data=%0d, need 5", data_o);
        end
        yumi_i = 1'b1;
        overflow_i = 1'b1;
        tick();
        yumi_i = 1'b0;
        overflow_i = 1'b0;
        n_cmp++;
        if (v_o !== 1'b1 || data_o !== 4'd1 || state_o !== 2'd1) begin
            n_err++;
            $display("FAIL yumi_and_ovf: v=%0b data=%0d state=%0d, need 1/1/1", v_o, data_o, state_o);
        end
        tick();
        n_cmp++;
        if (data_o !== 4'd1) begin
            n_err++;
            $display("FAIL hold: data=%0d, need 1", data_o);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        pulses(15);
        n_cmp++;
        if (data_o !== 4'd15 || lost_o !== 1'b0 || state_o !== 2'd2) begin
            n_err++;
            $display("FAIL sat_edge: data=%0d lost=%0b state=%0d, need 15/0/2", data_o, lost_o, state_o);
        end
        pulses(2);
        n_cmp++;
        if (data_o !== 4'd15 || lost_o !== 1'b1 || v_o !== 1'b1) begin
            n_err++;
            $display("FAIL sat_17: data=%0d lost=%0b v=%0b, need 15/1/1", data_o, lost_o, v_o);
        end
        lost_clr_i = 1'b1;
        tick();
        lost_clr_i = 1'b0;
        n_cmp++;
        if (lost_o !== 1'b0 || data_o !== 4'd15) begin
            n_err++;
            $display("FAIL lost_clr: lost=%0b data=%0d, need 0/15", lost_o, data_o);
        end
        lost_clr_i = 1'b1;
        overflow_i = 1'b1;
        tick();
        lost_clr_i = 1'b0;
        overflow_i = 1'b0;
        n_cmp++;
        if (lost_o !== 1'b1 || data_o !== 4'd15) begin
            n_err++;
            $display("FAIL set_wins: lost=%0b data=%0d, need 1/15", lost_o, data_o);
        end
        drain();
        n_cmp++;
        if (lost_o !== 1'b1 || data_o !== 4'd0 || v_o !== 1'b0) begin
            n_err++;
            $display("FAIL lost_sticky: lost=%0b data=%0d v=%0b, need 1/0/0", lost_o, data_o, v_o);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        pulses(7);
        n_cmp++;
        if (data_o !== 4'd7) begin
            n_err++;
            $display("FAIL seven_pulses: data=%0d, need 7", data_o);
        end
        #2;
        reset_i = 1'b1;
        #1;
        n_cmp++;
        if (v_o !== 1'b0 || data_o !== 4'd0) begin
            n_err++;
            $display("FAIL async_reset: v=%0b data=%0d, need 0/0", v_o, data_o);
        end
        #1;
        reset_i = 1'b0;
        overflow_i = 1'b1;
        tick();
        overflow_i = 1'b0;
        n_cmp++;
        if (v_o !== 1'b1 || data_o !== 4'd1) begin
            n_err++;
            $display("FAIL release_ovf: v=%0b data=%0d, need 1/1", v_o, data_o);
        end
    endtask

`ifdef BSG_COUNTER_OVERFLOW_COLLECTOR_TIMESTAMP_EN
    task automatic test_timestamp();
        reset_i = 1'b1;
        overflow_i = 1'b0;
        yumi_i = 1'b0;
        lost_clr_i = 1'b0;
        tick();
        reset_i = 1'b0;
        repeat (10) tick();
        pulses(1);
        repeat (9) tick();
        pulses(1);
        n_cmp++;
        if (timestamp_o !== 32'd10) begin
            n_err++;
            $display("FAIL ts_first: ts=%0d, need 10", timestamp_o);
        end
        drain();
        repeat (18) tick();
        pulses(1);
        n_cmp++;
        if (timestamp_o !== 32'd40) begin
            n_err++;
            $display("FAIL ts_second: ts=%0d, need 40", timestamp_o);
        end
    endtask
`endif

    task automatic test_random();
        int   cnt;
        logic lost;
        logic [4:0] exp;
        int   shown;
        do_reset();
        cnt = 0;
        lost = 1'b0;
        shown = 0;
        for (int i = 0; i < 10000; i++) begin
            overflow_i = 1'($urandom_range(0, 1));
            yumi_i = (cnt != 0) && ($urandom_range(0, 3) == 0);
            lost_clr_i = ($urandom_range(0, 7) == 0);
            if (yumi_i) begin
                cnt = overflow_i ? 1 : 0;
                if (lost_clr_i) lost = 1'b0;
            end else if (overflow_i && cnt == 15) begin
                lost = 1'b1;
            end else begin
                if (overflow_i) cnt++;
                if (lost_clr_i) lost = 1'b0;
            end
            exp_q.push_back({lost, 4'(cnt)});
            tick();
            exp = exp_q.pop_front();
            n_cmp++;
            if ({lost_o, data_o} !== exp || v_o !== (exp[3:0] != 4'd0)) begin
                n_err++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL random[%0d]: lost=%0b data=%0d v=%0b, need lost=%0b data=%0d", i, lost_o, data_o, v_o, exp[4], exp[3:0]);
                end
            end
        end
        overflow_i = 1'b0;
        yumi_i = 1'b0;
        lost_clr_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_three_pulses();
        test_yumi_with_overflow();
        test_saturation();
        test_async_reset();
`ifdef BSG_COUNTER_OVERFLOW_COLLECTOR_TIMESTAMP_EN
        test_timestamp();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
